// File: rtl/fifo_wr_ptr_sync.sv
// Write-domain pointer crossing stage of the async FIFO: gray-encodes the write
// pointer, synchronises the read gray pointer, and derives fill/almost-full/error status.
module fifo_wr_ptr_sync #(
  parameter int ADDR_WIDTH   = 3,
  parameter int NUM_STAGES   = 2,
  parameter int AFULL_THRESH = 6,
  localparam int PW          = ADDR_WIDTH + 1,
  localparam int DEPTH       = 1 << ADDR_WIDTH
) (
  input  logic          wclk,
  input  logic          wrst_n,
  input  logic [PW-1:0] wptr,
  input  logic [PW-1:0] rptr_gray,
  input  logic          werr_clr,
  output logic [PW-1:0] wptr_gray,
  output logic [PW-1:0] wq2_rptr,
  output logic [PW-1:0] wfill,
  output logic          wafull,
  output logic          werr
);

  localparam logic [PW-1:0] DEPTH_V  = PW'(DEPTH);
  localparam logic [PW-1:0] THRESH_V = PW'(AFULL_THRESH);

  logic [PW-1:0] wptr_gray_q, wptr_gray_d;
  logic [PW-1:0] sync_q [NUM_STAGES];
  logic [PW-1:0] sync_d [NUM_STAGES];
  logic [PW-1:0] prev_q, prev_d;
  logic [PW-1:0] wfill_q, wfill_d;
  logic          wafull_q, wafull_d;
  logic          werr_q, werr_d;

  logic [PW-1:0] rbin;
  logic [PW-1:0] diff;
  logic          gray_err;
  logic          range_err;

  always_comb begin
    wptr_gray_d = wptr ^ (wptr >> 1);
    sync_d[0]   = rptr_gray;
    for (int i = 1; i < NUM_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Gray-to-binary by XOR prefix from the MSB down.
  always_comb begin
    rbin = '0;
    rbin[PW-1] = sync_q[NUM_STAGES-1][PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      rbin[i] = rbin[i+1] ^ sync_q[NUM_STAGES-1][i];
    end
  end

  // Binary wptr is used on purpose so the gray register's latency is not added to wfill.
  always_comb begin
    diff      = wptr - rbin;
    gray_err  = ($countones(sync_q[NUM_STAGES-1] ^ prev_q) > 1);
    range_err = (diff > DEPTH_V);
    prev_d    = sync_q[NUM_STAGES-1];
    wfill_d   = diff;
    wafull_d  = (wfill_d >= THRESH_V);
    werr_d    = gray_err | range_err | (werr_q & ~werr_clr);
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wptr_gray_q <= '0;
      for (int i = 0; i < NUM_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev_q   <= '0;
      wfill_q  <= '0;
      wafull_q <= 1'b0;
      werr_q   <= 1'b0;
    end else begin
      wptr_gray_q <= wptr_gray_d;
      for (int i = 0; i < NUM_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      prev_q   <= prev_d;
      wfill_q  <= wfill_d;
      wafull_q <= wafull_d;
      werr_q   <= werr_d;
    end
  end

  assign wptr_gray = wptr_gray_q;
  assign wq2_rptr  = sync_q[NUM_STAGES-1];
  assign wfill     = wfill_q;
  assign wafull    = wafull_q;
  assign werr      = werr_q;

endmodule
